// File: rtl/cmd_ring_rd_afu.sv
// Consumer of a host-memory command ring: fetches 64 B entries over AXI-MM and pushes them into a local queue.
// Optional read-latency monitor (ring_lat_max) is enabled with `define CMD_RING_LAT_EN.
module cmd_ring_rd_afu #(
    parameter logic [11:0] ARID_VAL = 12'h0,
    parameter int unsigned PTR_W    = 32
) (
    input  logic             axi4_mm_clk,
    input  logic             axi4_mm_rst,
    output logic [11:0]      arid,
    output logic [63:0]      araddr,
    output logic [9:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic [2:0]       arprot,
    output logic [3:0]       arqos,
    output logic [4:0]       aruser,
    output logic             arvalid,
    output logic [3:0]       arcache,
    output logic [1:0]       arlock,
    output logic [3:0]       arregion,
    input  logic             arready,
    input  logic [11:0]      rid,
    input  logic [511:0]     rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             ruser,
    input  logic             rvalid,
    output logic             rready,
    input  logic [4:0]       csr_aruser,
    input  logic             csr_ring_en,
    input  logic [63:0]      csr_ring_base,
    input  logic [PTR_W-1:0] csr_ring_ptr_max,
    input  logic [PTR_W-1:0] csr_ring_tail_ptr,
    output logic [PTR_W-1:0] ring_head_ptr,
    output logic [63:0]      ring_rd_cnt,
    output logic [31:0]      ring_err_cnt,
    output logic             ring_err,
    input  logic             cmd_q_full,
    output logic             cmd_q_wrreq,
    output logic [511:0]     cmd_q_wrdata
`ifdef CMD_RING_LAT_EN
    ,
    output logic [15:0]      ring_lat_max
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RADDR, S_RDATA, S_PUSH} state_t;

    state_t           state_q, state_d;
    logic [63:0]      base_q;
    logic [511:0]     entry_q;
    logic [PTR_W-1:0] head_next_c;
    logic             fetch_ok_c, fetch_ok_adv_c, rsp_err_c;
    logic             capture_c, err_c, push_c;
    logic             unused_ok;

    assign unused_ok = ^{rid, rlast};

    // Constant AR attributes: single 64 B beat, fixed ID
    assign arid     = ARID_VAL;
    assign arlen    = 10'd0;
    assign arsize   = 3'b110;
    assign arburst  = 2'd0;
    assign arprot   = 3'd0;
    assign arqos    = 4'd0;
    assign aruser   = csr_aruser;
    assign arcache  = 4'd0;
    assign arlock   = 2'd0;
    assign arregion = 4'd0;

    assign araddr       = base_q + (64'(ring_head_ptr) << 6);
    assign arvalid      = (state_q == S_RADDR);
    assign rready       = (state_q == S_RDATA);
    assign cmd_q_wrreq  = push_c;
    assign cmd_q_wrdata = entry_q;

    assign head_next_c    = (ring_head_ptr >= csr_ring_ptr_max) ? '0 : ring_head_ptr + PTR_W'(1);
    assign fetch_ok_c     = csr_ring_en & (base_q != 64'd0) & (ring_head_ptr != csr_ring_tail_ptr) & ~cmd_q_full;
    assign fetch_ok_adv_c = csr_ring_en & (base_q != 64'd0) & (head_next_c != csr_ring_tail_ptr) & ~cmd_q_full;
    assign rsp_err_c      = (rresp != 2'b00) | ruser;

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next state and per-cycle datapath strobes
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        err_c     = 1'b0;
        push_c    = 1'b0;
        unique case (state_q)
            S_IDLE:  if (fetch_ok_c) state_d = S_RADDR;
            S_RADDR: if (arready) state_d = S_RDATA;
            S_RDATA: begin
                if (rvalid) begin
                    capture_c = 1'b1;
                    if (rsp_err_c) begin
                        err_c   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (!cmd_q_full) begin
                    push_c  = 1'b1;
                    state_d = fetch_ok_adv_c ? S_RADDR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Base latch, entry capture, head and counters
    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            base_q        <= 64'd0;
            entry_q       <= 512'd0;
            ring_head_ptr <= '0;
            ring_rd_cnt   <= 64'd0;
            ring_err_cnt  <= 32'd0;
            ring_err      <= 1'b0;
        end else begin
            if (base_q == 64'd0 && csr_ring_base != 64'd0) base_q <= csr_ring_base;
            if (capture_c) entry_q <= rdata;
            if (err_c || push_c) ring_head_ptr <= head_next_c;
            if (push_c) ring_rd_cnt <= ring_rd_cnt + 64'd1;
            if (err_c) begin
                ring_err     <= 1'b1;
                ring_err_cnt <= ring_err_cnt + 32'd1;
            end
        end
    end

`ifdef CMD_RING_LAT_EN
    logic [15:0] lat_cnt_q;

    // Cycles from AR handshake to R handshake; count starts at 1 on the cycle after arvalid&arready
    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            lat_cnt_q    <= 16'd0;
            ring_lat_max <= 16'd0;
        end else begin
            if (arvalid && arready) lat_cnt_q <= 16'd1;
            else if (rready && !rvalid && lat_cnt_q != 16'hFFFF) lat_cnt_q <= lat_cnt_q + 16'd1;
            if (rready && rvalid && lat_cnt_q > ring_lat_max) ring_lat_max <= lat_cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_ring_rd_afu.sv
// Randomized bench for cmd_ring_rd_afu: behavioural AXI slave, host producer and ring model with scoreboard.
module tb_cmd_ring_rd_afu;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  arid;
    logic [63:0]  araddr;
    logic [9:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic [4:0]   aruser;
    logic         arvalid;
    logic [3:0]   arcache;
    logic [1:0]   arlock;
    logic [3:0]   arregion;
    logic         arready;
    logic [11:0]  rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         ruser;
    logic         rvalid;
    logic         rready;
    logic [4:0]   csr_aruser;
    logic         csr_ring_en;
    logic [63:0]  csr_ring_base;
    logic [31:0]  csr_ring_ptr_max;
    logic [31:0]  csr_ring_tail_ptr;
    logic [31:0]  ring_head_ptr;
    logic [63:0]  ring_rd_cnt;
    logic [31:0]  ring_err_cnt;
    logic         ring_err;
    logic         cmd_q_full;
    logic         cmd_q_wrreq;
    logic [511:0] cmd_q_wrdata;
`ifdef CMD_RING_LAT_EN
    logic [15:0]  ring_lat_max;
`endif

    always #5 clk = ~clk;

    cmd_ring_rd_afu dut (
        .axi4_mm_clk(clk), .axi4_mm_rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arprot(arprot), .arqos(arqos), .aruser(aruser), .arvalid(arvalid), .arcache(arcache),
        .arlock(arlock), .arregion(arregion), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser), .rvalid(rvalid),
        .rready(rready), .csr_aruser(csr_aruser), .csr_ring_en(csr_ring_en),
        .csr_ring_base(csr_ring_base), .csr_ring_ptr_max(csr_ring_ptr_max),
        .csr_ring_tail_ptr(csr_ring_tail_ptr), .ring_head_ptr(ring_head_ptr),
        .ring_rd_cnt(ring_rd_cnt), .ring_err_cnt(ring_err_cnt), .ring_err(ring_err),
        .cmd_q_full(cmd_q_full), .cmd_q_wrreq(cmd_q_wrreq), .cmd_q_wrdata(cmd_q_wrdata)
`ifdef CMD_RING_LAT_EN
        , .ring_lat_max(ring_lat_max)
`endif
    );

    int unsigned  checks = 0;
    int unsigned  errors = 0;

    // Reference model: ring contents, consumer position, counters
    logic [63:0]  mbase;
    logic [31:0]  mhead, tail_v, ptr_max_v, salt;
    logic [63:0]  mcnt;
    logic [31:0]  merr;
    int unsigned  outst, mlatmax, lat_cur;
    logic [511:0] exp_q[$];
    // AXI slave and stimulus knobs
    bit           rd_pend, ar_seen, produce, full_force;
    int unsigned  rd_wait, ar_block;
    logic [63:0]  rd_addr, ar_addr0;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] entry_of(input logic [63:0] a);
        return {16{a[37:6] ^ salt}};
    endfunction

    function automatic logic [31:0] ring_next(input logic [31:0] h);
        return 32'((64'(h) + 64'd1) % (64'(ptr_max_v) + 64'd1));
    endfunction

    // One clock: host producer, AXI slave, queue side, push scoreboard
    task automatic step();
        bit err;
        @(negedge clk);
        if (produce && (outst + 2 <= ptr_max_v) && $urandom_range(0, 3) == 0) begin
            tail_v = ring_next(tail_v);
            outst++;
        end
        csr_ring_tail_ptr = tail_v;

        arready = 1'b0;
        if (arvalid) begin
            if (!ar_seen) begin
                check("araddr", araddr, mbase + (64'(mhead) << 6));
                ar_addr0 = araddr;
                ar_seen  = 1'b1;
            end else begin
                check("ar_stable", araddr, ar_addr0);
            end
            if (ar_block > 0) ar_block--;
            else if ($urandom_range(0, 2) == 0) begin
                arready = 1'b1;
                rd_pend = 1'b1;
                rd_wait = $urandom_range(0, 4);
                rd_addr = araddr;
                lat_cur = 1;
                ar_seen = 1'b0;
            end
        end

        rvalid = 1'b0;
        rresp  = 2'b00;
        ruser  = 1'b0;
        if (rd_pend && rready) begin
            if (rd_wait > 0) begin
                rd_wait--;
                lat_cur++;
            end else begin
                rvalid  = 1'b1;
                rdata   = entry_of(rd_addr);
                err     = ($urandom_range(0, 7) == 0);
                if (err) begin
                    if ($urandom_range(0, 1) == 0) rresp = 2'b10;
                    else ruser = 1'b1;
                    merr++;
                end else begin
                    exp_q.push_back(rdata);
                    mcnt++;
                end
                if (lat_cur > mlatmax) mlatmax = lat_cur;
                mhead   = ring_next(mhead);
                outst--;
                rd_pend = 1'b0;
            end
        end

        cmd_q_full = full_force || ($urandom_range(0, 3) == 0);
        #1;
        if (full_force) check("bp_wrreq", cmd_q_wrreq, 1'b0);
        if (cmd_q_wrreq) begin
            if (exp_q.size() == 0) check("push_unexp", 1'b1, 1'b0);
            else check("wrdata", cmd_q_wrdata, exp_q.pop_front());
        end
    endtask

    task automatic drain_and_check(input string ph);
        int n;
        produce    = 1'b0;
        full_force = 1'b0;
        n = 0;
        while ((outst != 0 || exp_q.size() != 0 || rd_pend) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) check({ph, "_drain_timeout"}, 1'b1, 1'b0);
        repeat (6) step();
        check({ph, "_head"}, ring_head_ptr, mhead);
        check({ph, "_head_eq_tail"}, ring_head_ptr, tail_v);
        check({ph, "_rd_cnt"}, ring_rd_cnt, mcnt);
        check({ph, "_err_cnt"}, ring_err_cnt, merr);
        check({ph, "_err"}, ring_err, merr != 0);
        check({ph, "_idle_arvalid"}, arvalid, 1'b0);
`ifdef CMD_RING_LAT_EN
        check({ph, "_lat_max"}, ring_lat_max, mlatmax);
`endif
    endtask

    task automatic model_reset();
        mhead = '0; tail_v = '0; mcnt = '0; merr = '0;
        outst = 0; mlatmax = 0; lat_cur = 0;
        exp_q.delete();
        rd_pend = 1'b0; ar_seen = 1'b0; ar_block = 0;
        produce = 1'b0; full_force = 1'b0;
    endtask

    initial begin
        int n;
        salt = $urandom();
        rst = 1'b1;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; ruser = 1'b0;
        rid = 12'h5A5; rlast = 1'b1; csr_aruser = 5'h0B; cmd_q_full = 1'b0;
        csr_ring_en = 1'b0; csr_ring_base = 64'd0; ptr_max_v = 32'd7;
        csr_ring_ptr_max = ptr_max_v;
        model_reset();
        csr_ring_tail_ptr = tail_v;

        #2;
        check("rst_head", ring_head_ptr, 32'd0);
        check("rst_rd_cnt", ring_rd_cnt, 64'd0);
        check("rst_err_cnt", ring_err_cnt, 32'd0);
        check("rst_err", ring_err, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_wrreq", cmd_q_wrreq, 1'b0);
        check("rst_wrdata", cmd_q_wrdata, 512'd0);
        check("rst_araddr", araddr, 64'd0);
        check("arsize", arsize, 3'b110);
        check("aruser", aruser, 5'h0B);
        check("arid", arid, 12'h0);

        @(negedge clk);
        rst = 1'b0;

        // Entries available but base still 0: nothing may be fetched
        tail_v = 32'd3; outst = 3;
        csr_ring_en = 1'b1;
        repeat (5) begin step(); check("base0_arvalid", arvalid, 1'b0); end

        // Disabled ring with entries pending: no fetch; base latches meanwhile
        csr_ring_en = 1'b0;
        csr_ring_base = 64'h1000; mbase = 64'h1000;
        repeat (10) begin step(); check("en0_arvalid", arvalid, 1'b0); end

        // Enable with arready held low for the first 5 address cycles
        ar_block = 5;
        csr_ring_en = 1'b1;
        for (n = 0; n < 300 && (outst != 0 || exp_q.size() != 0); n++) step();
        check("basic_done", (outst == 0 && exp_q.size() == 0), 1'b1);

        // Long randomized run with wraps; base CSR change after latch must be ignored
        produce = 1'b1;
        repeat (250) step();
        csr_ring_base = 64'hDEAD_0000;
        repeat (250) step();

        // Sustained queue-full window
        full_force = 1'b1;
        repeat (25) step();
        check("bp_no_ar", arvalid, 1'b0);
        full_force = 1'b0;
        repeat (200) step();
        drain_and_check("ph1");

        // Async reset while a read response is awaited
        produce = 1'b1;
        for (n = 0; n < 500 && !(rready && !rvalid); n++) step();
        check("reach_rdata", rready && !rvalid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_rready", rready, 1'b0);
        check("arst_arvalid", arvalid, 1'b0);
        check("arst_head", ring_head_ptr, 32'd0);
        check("arst_rd_cnt", ring_rd_cnt, 64'd0);
        check("arst_err", ring_err, 1'b0);
        check("arst_wrdata", cmd_q_wrdata, 512'd0);
        model_reset();
        arready = 1'b0; rvalid = 1'b0;
        ptr_max_v = 32'd3;
        csr_ring_ptr_max = ptr_max_v;
        csr_ring_tail_ptr = tail_v;
        csr_ring_base = 64'h8_0000_0040; mbase = 64'h8_0000_0040;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Small ring after reset: base relatched to the new value
        produce = 1'b1;
        repeat (400) step();
        drain_and_check("ph2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
